seg7_scan_driver: RTL and testbench

// Parametrised multiplexed 7-segment display driver for signed two's-complement results.

---
 rtl/seg7_scan_driver.sv | 216 +++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver for signed results: sequential double-dabble
// conversion behind a valid/ready handshake, leading-zero blanking and an error pattern.
module seg7_scan_driver #(
    parameter int DATA_W         = 10,
    parameter int MAG_DIGITS     = 3,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_error,
    output logic [6:0]            seg,
    output logic [MAG_DIGITS:0]   digit_en,
    output logic                  busy
);

    localparam int POS   = MAG_DIGITS + 1;
    localparam int BCD_W = 4 * MAG_DIGITS;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(POS);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t             state_r;
    logic [DATA_W-1:0]  mag_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sign_r;
    logic               err_r;
    logic [BCD_W-1:0]   disp_bcd_r;
    logic               disp_sign_r;
    logic               disp_err_r;
    logic [PRE_W-1:0]   pre_r;
    logic [IDX_W-1:0]   idx_r;
    logic [DATA_W-1:0]  mag_in_s;
    logic [6:0]         pat_s;

    // Active-low glyph for one decimal digit; non-decimal codes show blank.
    function automatic logic [6:0] digit_map(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // One double-dabble step: correct nibbles >= 5, then shift in the next magnitude bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < MAG_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = adj[4*i +: 4];
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // Active-low glyph for a scan position, including sign, error and zero blanking.
    function automatic logic [6:0] pos_glyph(input logic [BCD_W-1:0] bcd,
                                             input logic neg,
                                             input logic err,
                                             input logic [IDX_W-1:0] idx);
        logic [6:0] g;
        logic [3:0] d;
        logic       lead_zero;
        g         = SEG_BLANK;
        d         = 4'd0;
        lead_zero = 1'b1;
        for (int i = 0; i < MAG_DIGITS; i++) begin
            if (i == int'(idx)) begin
                d = bcd[4*i +: 4];
            end
            if (i >= int'(idx) && bcd[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        if (err) begin
            g = SEG_DASH;
        end else if (idx == IDX_W'(MAG_DIGITS)) begin
            g = neg ? SEG_DASH : SEG_BLANK;
        end else if (lead_zero && idx != '0) begin
            g = SEG_BLANK;
        end else begin
            g = digit_map(d);
        end
        return g;
    endfunction

    function automatic logic [6:0] apply_pol(input logic [6:0] g);
        return SEG_ACTIVE_LOW ? g : ~g;
    endfunction

    // Absolute value; the most negative input maps to its exact unsigned magnitude.
    always_comb begin
        mag_in_s = in_data;
        if (in_data[DATA_W-1]) begin
            mag_in_s = (~in_data) + DATA_W'(1);
        end else begin
            mag_in_s = in_data;
        end
    end

    // Glyph for the currently indexed position from the stable display registers.
    always_comb begin
        pat_s = apply_pol(pos_glyph(disp_bcd_r, disp_sign_r, disp_err_r, idx_r));
    end

    // Handshake and conversion FSM; display registers change only in LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            mag_r       <= '0;
            bcd_r       <= '0;
            cnt_r       <= '0;
            sign_r      <= 1'b0;
            err_r       <= 1'b0;
            disp_bcd_r  <= '0;
            disp_sign_r <= 1'b0;
            disp_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_r   <= in_data[DATA_W-1];
                        err_r    <= in_error;
                        mag_r    <= mag_in_s;
                        bcd_r    <= '0;
                        cnt_r    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_CONV;
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    bcd_r <= dabble_step(bcd_r, mag_r[DATA_W-1]);
                    mag_r <= {mag_r[DATA_W-2:0], 1'b0};
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        cnt_r   <= '0;
                        state_r <= ST_LOAD;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_CONV;
                    end
                end
                ST_LOAD: begin
                    disp_bcd_r  <= bcd_r;
                    disp_sign_r <= sign_r;
                    disp_err_r  <= err_r;
                    in_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan prescaler, position index and the registered pin outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_r    <= '0;
            idx_r    <= '0;
            digit_en <= {{MAG_DIGITS{1'b0}}, 1'b1};
            seg      <= apply_pol(SEG_BLANK);
        end else begin
            if (pre_r == PRE_W'(SCAN_DIV - 1)) begin
                pre_r <= '0;
                if (idx_r == IDX_W'(MAG_DIGITS)) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
            digit_en <= {{MAG_DIGITS{1'b0}}, 1'b1} << idx_r;
            seg      <= pat_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a timeline model checked every cycle, plus
// hand-computed glyph expectations for directed values.
module tb_seg7_scan_driver;

    localparam int DATA_W     = 10;
    localparam int MAG_DIGITS = 3;
    localparam int SCAN_DIV   = 4;
    localparam int POS        = MAG_DIGITS + 1;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b1111110;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_error = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_ready;
    logic              busy;
    logic [6:0]        seg;
    logic [MAG_DIGITS:0] digit_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DATA_W(DATA_W), .MAG_DIGITS(MAG_DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_error(in_error), .seg(seg), .digit_en(digit_en), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return BLANK;
        endcase
    endfunction

    // What position p must show for a displayed signed value, from decimal arithmetic.
    function automatic logic [6:0] model_seg(input int p, input int val, input bit err);
        int m;
        int scale;
        if (err) return DASH;
        if (p == MAG_DIGITS) return (val < 0) ? DASH : BLANK;
        m = (val < 0) ? -val : val;
        scale = 1;
        for (int i = 0; i < p; i++) scale = scale * 10;
        if (p > 0 && m < scale) return BLANK;
        return glyph_of((m / scale) % 10);
    endfunction

    // Cycle-by-cycle model: k counts edges since reset, accepts are timestamped.
    initial begin
        int k;
        bit started;
        bit ready_m;
        bit acc_v;
        int acc_edge;
        int acc_val;
        bit acc_err;
        int disp_val;
        bit disp_err;
        int p;
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        started = 1'b0; k = 0; ready_m = 1'b1; acc_v = 1'b0; acc_edge = 0;
        acc_val = 0; acc_err = 1'b0; disp_val = 0; disp_err = 1'b0;
        exp_en = 4'b0001; exp_seg = BLANK;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                started = 1'b1; k = 0; acc_v = 1'b0; disp_val = 0; disp_err = 1'b0;
                ready_m = 1'b1; exp_en = 4'b0001; exp_seg = BLANK;
            end else if (started) begin
                k++;
                p = ((k - 1) / SCAN_DIV) % POS;
                exp_en  = 4'b0001 << p;
                exp_seg = model_seg(p, disp_val, disp_err);
                if (acc_v && k == acc_edge + DATA_W + 1) begin
                    disp_val = acc_val;
                    disp_err = acc_err;
                end
                if (in_valid && ready_m) begin
                    acc_v = 1'b1; acc_edge = k; acc_val = $signed(in_data); acc_err = in_error;
                end
                ready_m = !(acc_v && k <= acc_edge + DATA_W);
            end
            if (started) begin
                chk("model_digit_en", digit_en, exp_en);
                chk("model_seg", seg, exp_seg);
                chk("model_in_ready", in_ready, ready_m);
                chk("model_busy", busy, !ready_m);
            end
        end
    end

    task automatic expect_pos(input int pos, input logic [6:0] exp_seg, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (digit_en !== (4'b0001 << pos) && n < 40);
        chk({name, "_en"}, digit_en, 4'b0001 << pos);
        chk(name, seg, exp_seg);
    endtask

    // Send one value; n returns the number of samples with in_ready low after the accept.
    task automatic send(input logic [DATA_W-1:0] d, input logic e, output int n);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_error = e;
        @(posedge clk); #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk); in_valid = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        expect_pos(0, 7'b0000001, "idle_p0");
        expect_pos(1, BLANK, "idle_p1");
        expect_pos(2, BLANK, "idle_p2");
        expect_pos(3, BLANK, "idle_p3");
        n = 0;
        while (digit_en !== 4'b0010 && n < 40) begin @(posedge clk); #1; n++; end
        cnt = 0;
        while (digit_en === 4'b0010 && cnt < 40) begin cnt++; @(posedge clk); #1; end
        chk("scan_dwell", cnt, 4);

        send(10'd123, 1'b0, n);
        chk("ready_low_123", n, 11);
        expect_pos(0, 7'b0000110, "v123_p0");
        expect_pos(1, 7'b0010010, "v123_p1");
        expect_pos(2, 7'b1001111, "v123_p2");
        expect_pos(3, BLANK, "v123_p3");

        send(10'h3FF, 1'b0, n);
        expect_pos(0, 7'b1001111, "neg1_p0");
        expect_pos(1, BLANK, "neg1_p1");
        expect_pos(2, BLANK, "neg1_p2");
        expect_pos(3, DASH, "neg1_p3");

        send(10'h200, 1'b0, n);
        expect_pos(0, 7'b0010010, "neg512_p0");
        expect_pos(1, 7'b1001111, "neg512_p1");
        expect_pos(2, 7'b0100100, "neg512_p2");
        expect_pos(3, DASH, "neg512_p3");

        send(10'd40, 1'b0, n);
        expect_pos(0, 7'b0000001, "v40_p0");
        expect_pos(1, 7'b1001100, "v40_p1");
        expect_pos(2, BLANK, "v40_p2");

        send(10'd5, 1'b1, n);
        expect_pos(0, DASH, "err_p0");
        expect_pos(1, DASH, "err_p1");
        expect_pos(2, DASH, "err_p2");
        expect_pos(3, DASH, "err_p3");

        send(10'd7, 1'b0, n);
        expect_pos(0, 7'b0001111, "v7_p0");
        expect_pos(3, BLANK, "v7_p3");

        // 999 accepted, a stray valid pulse while busy, then reset mid-conversion.
        @(negedge clk); in_valid = 1'b1; in_data = 10'd999; in_error = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 10'd888;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1'b1);
        expect_pos(0, 7'b0000001, "rst_p0");
        expect_pos(1, BLANK, "rst_p1");

        send(10'd456, 1'b0, n);
        chk("ready_low_456", n, 11);
        expect_pos(0, 7'b0100000, "v456_p0");
        expect_pos(1, 7'b0100100, "v456_p1");
        expect_pos(2, 7'b1001100, "v456_p2");

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
